aes_block_fifo: RTL and testbench

- 128-bit first-word-fall-through block FIFO between byte_stacker (32→128 packer) and the cipher core / byte_unstacker.
- Absorbs backpressure so the stacker keeps accepting 32-bit words while the core is busy.
- Uses the same valid/ready, enable and clear semantics as the neighbouring stream stages.
- Adds occupancy status for the control FSM.

---
 rtl/aes_block_fifo.sv | 80 ++++++++
 tb/tb_aes_block_fifo.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/aes_block_fifo.sv
// First-word-fall-through FIFO of 128-bit blocks between the byte stacker and the cipher core.
// Carries valid/ready handshakes with stage enable and synchronous flush, plus occupancy status.
module aes_block_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             enable_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [127:0]     word_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [127:0]     word_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [127:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full, empty, push, pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // Handshakes depend only on registered state, never on the partner's signal.
    assign ready_o = enable_i & ~full & ~rst_i & ~clr_i;
    assign valid_o = enable_i & ~empty & ~rst_i & ~clr_i;
    assign push    = valid_i & ready_o;
    assign pop     = valid_o & ready_i;

    assign word_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;
    assign full_o  = full;
    assign empty_o = empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; push is already blocked during reset and flush.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= word_i;
        end
    end

endmodule

// File: tb/tb_aes_block_fifo.sv
// Self-checking bench for aes_block_fifo: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_aes_block_fifo;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_i, clr_i, enable_i, valid_i, ready_i;
    logic [127:0]     word_i;
    logic             ready_o, valid_o, full_o, empty_o;
    logic [127:0]     word_o;
    logic [CNT_W-1:0] count_o;

    int total = 0;
    int bad   = 0;

    logic [127:0] mq[$];
    logic [127:0] got_q[$];

    always #5 clk = ~clk;

    aes_block_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .clr_i    (clr_i),
        .enable_i (enable_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .word_i   (word_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .word_o   (word_o),
        .count_o  (count_o),
        .full_o   (full_o),
        .empty_o  (empty_o)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic cyc(input logic r, input logic c, input logic e, input logic v,
                       input logic [127:0] w, input logic rdy);
        logic         er, ev;
        logic [127:0] ew;
        int           n;
        @(negedge clk);
        rst_i = r; clr_i = c; enable_i = e; valid_i = v; word_i = w; ready_i = rdy;
        #1;
        n  = mq.size();
        er = e && (n < DEPTH) && !r && !c;
        ev = e && (n > 0) && !r && !c;
        ew = ev ? mq[0] : 128'h0;
        check("ready", 128'(ready_o), 128'(er));
        check("valid", 128'(valid_o), 128'(ev));
        check("word", word_o, ew);
        check("count", 128'(count_o), 128'(n));
        check("full", 128'(full_o), 128'(n == DEPTH));
        check("empty", 128'(empty_o), 128'(n == 0));
        check("count_le_depth", 128'(count_o <= CNT_W'(DEPTH)), 128'(1));
        if (valid_o && rdy) got_q.push_back(word_o);
        @(posedge clk);
        if (r || c) begin
            mq.delete();
        end else begin
            if (ev && rdy) void'(mq.pop_front());
            if (v && er) mq.push_back(w);
        end
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 128'h0, rdy);
    endtask

    logic [31:0]  vec [8];
    logic [127:0] blk;
    int           hits;

    initial begin
        vec = '{32'hAAAAAAAA, 32'hBBBBBBBB, 32'h12345678, 32'h55555555,
                32'hBAAAAAAA, 32'hFFFFFFFF, 32'hABAAAAAA, 32'h00000000};

        // Bring-up reset without checks: state is unknown until the first edge.
        rst_i = 1'b1; clr_i = 1'b0; enable_i = 1'b1; valid_i = 1'b0;
        ready_i = 1'b0; word_i = '0;
        repeat (2) @(posedge clk);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 128'h1, 1'b1);

        // Single block fall-through.
        cyc(1'b0, 1'b0, 1'b1, 1'b1, {16{8'hAA}}, 1'b1);
        idle(2, 1'b1);

        // Fill to full, fifth block held off, then drain in order.
        for (int i = 1; i <= 5; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 128'(i), 1'b0);
        idle(5, 1'b1);

        // Steady streaming at count 2 across pointer wrap.
        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 128'(100 + i), 1'b0);
        for (int i = 2; i < 12; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 128'(100 + i), 1'b1);
        idle(3, 1'b1);

        // Flush while pushing: the flushed-cycle block must never appear.
        got_q.delete();
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 128'(200 + i), 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, {16{8'hBB}}, 1'b1);
        idle(3, 1'b1);
        hits = 0;
        foreach (got_q[i]) if (got_q[i] == {16{8'hBB}}) hits++;
        check("clr_dropped", 128'(hits), 128'(0));

        // Enable low freezes everything.
        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 128'(300 + i), 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 128'(400 + i), 1'b1);
        idle(3, 1'b1);

        // Packed 32-bit vector stream with intermittent ready.
        got_q.delete();
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 4; j++) blk[32*j +: 32] = vec[4*k + j];
            cyc(1'b0, 1'b0, 1'b1, 1'b1, blk, 1'(k));
        end
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 128'h0, 1'($urandom_range(0, 1)));
        idle(3, 1'b1);
        check("chain_blocks", 128'(got_q.size()), 128'(2));
        if (got_q.size() == 2) begin
            for (int i = 0; i < 8; i++) begin
                blk = got_q[i / 4];
                check($sformatf("chain_word%0d", i), 128'(blk[32*(i%4) +: 32]), 128'(vec[i]));
            end
        end

        // Random traffic with occasional reset, flush and stall.
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 127) == 0),
                1'($urandom_range(0, 63) == 0),
                1'($urandom_range(0, 7) != 0),
                1'($urandom_range(0, 1)),
                {$urandom, $urandom, $urandom, $urandom},
                ((i / 200) % 2 == 0) ? 1'($urandom_range(0, 3) != 0)
                                     : 1'($urandom_range(0, 3) == 0));
        end
        idle(6, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
